// File: rtl/rv32i_mem.sv
// RV32I MEM stage: req/ack data-memory access with lane steering and load extension.
// Feeds the MEM/WB register; wb_data doubles as the mem_wb forwarding source.
module rv32i_mem #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_d,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        mem_exc,
    output logic        bus_err
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q;
    logic        req_q, we_q, rw_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic [31:0] cnt_q;
    logic        wb_valid_q, wb_rw_q, exc_q, berr_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        access, legal, timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, shifted, load_d;

    always_comb begin
        access = ex_valid & (ex_mem_read | ex_mem_write);
        legal  = 1'b0;
        unique case (ex_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~ex_alu_result[0];
            3'b010:  legal = (ex_alu_result[1:0] == 2'b00);
            3'b100:  legal = ~ex_mem_write;
            3'b101:  legal = ~ex_mem_write & ~ex_alu_result[0];
            default: legal = 1'b0;
        endcase
        if (ex_mem_read & ex_mem_write)
            legal = 1'b0;
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_rs2_d;
        unique case (ex_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_alu_result[1:0];
                wdata_d = {4{ex_rs2_d[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << ex_alu_result[1:0];
                wdata_d = {2{ex_rs2_d[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = ex_rs2_d;
            end
        endcase
    end

    always_comb begin
        shifted = dmem_rdata >> {lane_q, 3'b000};
        unique case (f3_q)
            3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_d = {24'd0, shifted[7:0]};
            3'b101:  load_d = {16'd0, shifted[15:0]};
            default: load_d = dmem_rdata;
        endcase
    end

    // ack in the limit cycle takes priority over the timeout
    assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == ACK_TIMEOUT - 1);

    always_comb begin
        if (state_q == IDLE)
            mem_stall = rst_n & access & legal;
        else
            mem_stall = rst_n & ~dmem_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            exc_q  <= 1'b0;
            berr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (access && legal) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        we_q       <= ex_mem_write;
                        rw_q       <= ex_reg_write & (ex_rd_addr != 5'd0);
                        addr_q     <= {ex_alu_result[31:2], 2'b00};
                        wdata_q    <= wdata_d;
                        be_q       <= be_d;
                        f3_q       <= ex_funct3;
                        lane_q     <= ex_alu_result[1:0];
                        rd_q       <= ex_rd_addr;
                        cnt_q      <= '0;
                        wb_valid_q <= 1'b0;
                    end else if (access) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= ex_rd_addr;
                        wb_rw_q    <= 1'b0;
                        wb_data_q  <= ex_alu_result;
                        exc_q      <= 1'b1;
                    end else begin
                        wb_valid_q <= ex_valid;
                        wb_rd_q    <= ex_rd_addr;
                        wb_rw_q    <= ex_reg_write;
                        wb_data_q  <= ex_alu_result;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= ~we_q & rw_q;
                        wb_data_q  <= we_q ? 32'd0 : load_d;
                    end else if (timeout) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= 1'b0;
                        wb_data_q  <= '0;
                        berr_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd_addr   = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign mem_exc      = exc_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_rv32i_mem.sv
// Directed bench for rv32i_mem: transaction-level model plus per-cycle compare.
// Bus memory is played by the stimulus tasks with programmable wait cycles.
module tb_rv32i_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_rs2_d = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, mem_exc, bus_err;
    logic [4:0]  wb_rd_addr;

    always #5 clk = ~clk;

    rv32i_mem #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_rs2_d(ex_rs2_d), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .mem_exc(mem_exc), .bus_err(bus_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        chk_data;
        logic [31:0] data;
        logic        exc;
        logic        berr;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         e_cmp;
    int          checks = 0;
    int          failures = 0;
    logic        bus_on = 1'b0;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal_of(bit rd_, bit wr, logic [2:0] f3, logic [31:0] a);
        if (rd_ && wr) return 1'b0;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        return (a % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] be_of(logic [2:0] f3, logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] wdata_of(logic [2:0] f3, logic [31:0] rs2);
        if (nbytes(f3) == 1) return 32'(rs2[7:0]) * 32'h01010101;
        if (nbytes(f3) == 2) return 32'(rs2[15:0]) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] load_of(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
        longint v;
        int     n;
        n = nbytes(f3);
        v = longint'((64'(rdata) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 64'd1));
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req) begin
                if (!bus_on) chk("unexpected_req", 32'(dmem_req), 32'd0);
                else begin
                    chk("bus_addr", dmem_addr, exp_addr);
                    chk("bus_be", 32'(dmem_be), 32'(exp_be));
                    chk("bus_we", 32'(dmem_we), 32'(exp_we));
                    if (exp_we) chk("bus_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (wb_valid) begin
                if (exp_q.size() == 0) chk("unexpected_wb", 32'(wb_valid), 32'd0);
                else begin
                    e_cmp = exp_q.pop_front();
                    chk("wb_rd", 32'(wb_rd_addr), 32'(e_cmp.rd));
                    chk("wb_rw", 32'(wb_reg_write), 32'(e_cmp.rw));
                    chk("wb_exc", 32'(mem_exc), 32'(e_cmp.exc));
                    chk("wb_berr", 32'(bus_err), 32'(e_cmp.berr));
                    if (e_cmp.chk_data) chk("wb_data", wb_data, e_cmp.data);
                end
            end else begin
                chk("pulse_idle", {30'd0, mem_exc, bus_err}, 32'd0);
            end
        end
    end

    task automatic issue(bit rd_, bit wr, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] rs2, logic [4:0] rd, bit rw, int waits,
                         logic [31:0] rdata, bit ack, string tag);
        wb_t e;
        int  stalls;
        int  n;
        bit  acc;
        acc = rd_ | wr;
        stalls = 0;
        ex_valid = 1'b1; ex_mem_read = rd_; ex_mem_write = wr;
        ex_funct3 = f3; ex_alu_result = a; ex_rs2_d = rs2;
        ex_rd_addr = rd; ex_reg_write = rw;
        e.rd = rd; e.exc = 1'b0; e.berr = 1'b0; e.chk_data = 1'b1;
        e.data = a; e.rw = rw;
        if (!acc) begin
            exp_q.push_back(e);
            @(negedge clk);
            chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            return;
        end
        if (!legal_of(rd_, wr, f3, a)) begin
            e.rw = 1'b0; e.exc = 1'b1; e.chk_data = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
            chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            return;
        end
        exp_addr = a & ~32'd3;
        exp_be = be_of(f3, a);
        exp_we = wr;
        exp_wdata = wdata_of(f3, rs2);
        bus_on = 1'b1;
        e.rw = rd_ && rw && (rd != 5'd0);
        e.chk_data = rd_;
        e.data = load_of(f3, a, rdata);
        if (!ack) begin
            e.rw = 1'b0; e.berr = 1'b1; e.chk_data = 1'b0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        stalls += int'(mem_stall);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_alu_result = ~a;
        ex_rs2_d = ~rs2;
        if (!ack) begin
            n = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!dmem_req) break;
                n++;
            end
            chk({tag, "_req_cycles"}, 32'(n), 32'd4);
            chk({tag, "_bus_err"}, 32'(bus_err), 32'd1);
            chk({tag, "_stall_after"}, 32'(mem_stall), 32'd0);
            bus_on = 1'b0;
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk({tag, "_req_wait"}, 32'(dmem_req), 32'd1);
            stalls += int'(mem_stall);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        chk({tag, "_stall_ack"}, 32'(mem_stall), 32'd0);
        cap_addr = dmem_addr; cap_be = dmem_be;
        cap_wdata = dmem_wdata; cap_we = dmem_we;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        bus_on = 1'b0;
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(1 + waits));
    endtask

    task automatic pin_wb(string tag, logic [31:0] exp);
        @(negedge clk);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_wb_lit"}, wb_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb", {29'd0, wb_valid, wb_reg_write, mem_exc}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_bus", dmem_addr | dmem_wdata | 32'(dmem_be) | 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        issue(1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 2, 32'hDEADBEEF, 1, "lw");
        chk("lw_be", 32'(cap_be), 32'h0000000F);
        pin_wb("lw", 32'hDEADBEEF);

        issue(1, 0, 3'b000, 32'h203, 0, 5'd6, 1, 1, 32'h80112233, 1, "lb");
        chk("lb_be", 32'(cap_be), 32'h00000008);
        pin_wb("lb", 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h203, 0, 5'd7, 1, 0, 32'h80112233, 1, "lbu");
        pin_wb("lbu", 32'h00000080);

        issue(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0, 0, 1, 0, 1, "sh");
        chk("sh_addr", cap_addr, 32'h300);
        chk("sh_be", 32'(cap_be), 32'h0000000C);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_we", 32'(cap_we), 32'd1);

        issue(1, 0, 3'b010, 32'h101, 0, 5'd8, 1, 0, 0, 1, "lw_mis");
        issue(0, 0, 3'b000, 32'h55, 0, 5'd9, 1, 0, 0, 1, "add");
        pin_wb("add", 32'h00000055);

        issue(1, 0, 3'b001, 32'h402, 0, 5'd10, 1, 0, 32'h80017FFF, 1, "lh");
        pin_wb("lh", 32'hFFFF8001);
        issue(1, 0, 3'b101, 32'h402, 0, 5'd11, 1, 2, 32'h80017FFF, 1, "lhu");
        issue(1, 0, 3'b001, 32'h400, 0, 5'd12, 1, 0, 32'h80017FFF, 1, "lh0");
        issue(1, 0, 3'b010, 32'h404, 0, 5'd0, 1, 1, 32'h12345678, 1, "lw_x0");
        issue(0, 1, 3'b000, 32'h001, 32'h12345678, 5'd0, 0, 0, 0, 1, "sb");
        chk("sb_wdata", cap_wdata, 32'h78787878);
        chk("sb_be", 32'(cap_be), 32'h00000002);
        issue(0, 1, 3'b010, 32'h010, 32'hCAFEF00D, 5'd0, 0, 3, 0, 1, "sw");

        issue(0, 1, 3'b100, 32'h20, 0, 5'd1, 0, 0, 0, 1, "sbu_ill");
        issue(1, 1, 3'b010, 32'h20, 0, 5'd2, 1, 0, 0, 1, "rw_ill");
        issue(1, 0, 3'b001, 32'h03, 0, 5'd3, 1, 0, 0, 1, "lh_mis");
        issue(1, 0, 3'b011, 32'h20, 0, 5'd4, 1, 0, 0, 1, "f3_ill");
        issue(0, 0, 3'b000, 32'h77, 0, 5'd13, 0, 0, 0, 1, "nop_rw0");

        issue(1, 0, 3'b010, 32'h500, 0, 5'd14, 1, 0, 0, 0, "tmo");
        issue(1, 0, 3'b010, 32'h504, 0, 5'd15, 1, 3, 32'h0BADF00D, 1, "ack_lim");

        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_alu_result = 32'h600; ex_rd_addr = 5'd16;
        ex_reg_write = 1'b1;
        exp_addr = 32'h600; exp_be = 4'hF; exp_we = 1'b0; bus_on = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(mem_stall), 32'd0);
        bus_on = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 0, 3'b010, 32'h600, 0, 5'd16, 1, 1, 32'h13579BDF, 1, "lw_post");
        pin_wb("lw_post", 32'h13579BDF);

        repeat (3) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
